// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with registered pins.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             count_q, count_d;
    logic [IW-1:0]             index_q, index_d;
    logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
    logic [6:0]                seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
    logic                      frame_done_q, frame_done_d;
    // Low through reset and the first edge after release, so a load on that edge is dropped.
    logic                      armed_q, armed_d;

    logic       tick;
    logic [3:0] nibble;
    logic [6:0] glyph;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic       all_zero;
    logic       lz_hit;
`endif

    always_comb begin
        tick         = (count_q == COUNT_LAST);
        count_d      = tick ? '0 : count_q + 1'b1;
        index_d      = index_q;
        if (tick) begin
            index_d = (index_q == INDEX_LAST) ? '0 : index_q + 1'b1;
        end
        frame_done_d = tick && (index_q == INDEX_LAST);
        armed_d      = 1'b1;
        disp_d       = (load && armed_q) ? value : disp_q;

        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index_q == IW'(k)) begin
                nibble = disp_q[4*k +: 4];
            end
        end

        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        if (!hex_mode && (nibble > 4'd9)) begin
            glyph = 7'h3F;
        end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Walk from the most significant digit down; digit 0 never qualifies.
        all_zero = 1'b1;
        lz_hit   = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (disp_q[4*k +: 4] == 4'h0);
            if ((k > 0) && all_zero && (index_q == IW'(k))) begin
                lz_hit = 1'b1;
            end
        end
        if (lz_hit) begin
            glyph = 7'h7F;
        end
`endif

        seg_n_d = blank ? 7'h7F : glyph;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_n_d[k] = blank || (index_q != IW'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            index_q      <= '0;
            disp_q       <= '0;
            seg_n_q      <= 7'h7F;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            index_q      <= index_d;
            disp_q       <= disp_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
            armed_q      <= armed_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed and random scan checks against a cycle-count reference model.
// Define SEG7_LEADING_ZERO_BLANK_EN for both bench and design to check leading-zero blanking.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic        load;
    logic        hex_mode;
    logic        blank;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int          checks   = 0;
    int          failures = 0;
    int          n;
    logic [15:0] disp_m;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .value     (value),
        .load      (load),
        .hex_mode  (hex_mode),
        .blank     (blank),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .frame_done(frame_done)
    );

    function automatic logic [6:0] exp_seg(int idx, logic [15:0] d, logic hm, logic bl);
        logic [15:0] sh;
        logic [3:0]  nib;
        sh  = d >> (4 * idx);
        nib = sh[3:0];
        if (bl) return 7'h7F;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((idx > 0) && (sh == 16'h0)) return 7'h7F;
`endif
        if (!hm && (nib > 4'd9)) return 7'h3F;
        return glyph_tab[nib];
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n, got, exp);
        end
    endtask

    // Called at a falling edge: drive inputs, predict, take one rising edge, check, return at falling edge.
    task automatic step(input logic [15:0] v, input logic ld, input logic hm, input logic bl);
        int         idx;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        logic       take;
        value    = v;
        load     = ld;
        hex_mode = hm;
        blank    = bl;
        idx  = (n / PS) % ND;
        es   = exp_seg(idx, disp_m, hm, bl);
        ea   = bl ? 4'hF : ~(4'b0001 << idx);
        ef   = (((n + 1) % (PS * ND)) == 0);
        take = ld && (n >= 1);
        @(posedge clk);
        #1;
        n++;
        if (take) disp_m = v;
        check("seg_n", {1'b0, seg_n}, {1'b0, es});
        check("an_n", {4'h0, an_n}, {4'h0, ea});
        check("frame_done", {7'h0, frame_done}, {7'h0, ef});
        @(negedge clk);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_seg_n"}, {1'b0, seg_n}, 8'h7F);
        check({tag, "_an_n"}, {4'h0, an_n}, 8'h0F);
        check({tag, "_frame_done"}, {7'h0, frame_done}, 8'h00);
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        value    = 16'h0;
        hex_mode = 1'b1;
        blank    = 1'b0;
        n        = 0;
        disp_m   = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_pins("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Release edge, then load 1234 and run two frames.
        step(16'h0, 1'b0, 1'b1, 1'b0);
        check("first_seg_const", {1'b0, seg_n}, 8'h40);
        check("first_an_const", {4'h0, an_n}, 8'h0E);
        step(16'h1234, 1'b1, 1'b1, 1'b0);
        repeat (32) step(16'h0, 1'b0, 1'b1, 1'b0);

        // Hex glyphs versus dash mode.
        step(16'hABCF, 1'b1, 1'b0, 1'b0);
        repeat (16) step(16'($urandom), 1'b0, 1'b0, 1'b0);
        repeat (16) step(16'($urandom), 1'b0, 1'b1, 1'b0);

        // Six-cycle blank pulse starting mid-digit.
        while ((n % PS) != 1) step(16'h0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(16'h0, 1'b0, 1'b1, 1'b1);
        repeat (20) step(16'h0, 1'b0, 1'b1, 1'b0);

        // Leading-zero pattern.
        step(16'h0050, 1'b1, 1'b1, 1'b0);
        repeat (16) step(16'h0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic, including loads coinciding with ticks.
        repeat (200) step(16'($urandom), ($urandom % 4) == 0, 1'($urandom % 2), ($urandom % 8) == 0);

        // Reset at digit 2 while loading; load held on the release edge.
        step(16'h9876, 1'b1, 1'b1, 1'b0);
        while (((n / PS) % ND) != 2 || (n % PS) != 1) step(16'h0, 1'b0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        load    = 1'b1;
        value   = 16'h5555;
        #1;
        check_reset_pins("async_rst");
        @(posedge clk);
        #1;
        check_reset_pins("held_rst");
        @(negedge clk);
        reset_n = 1'b1;
        n       = 0;
        disp_m  = 16'h0;
        step(16'h5555, 1'b1, 1'b1, 1'b0);
        repeat (16) step(16'h5555, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, is the number of multiplexed digits; legal range 1..8.
REQ-002 Parameter PRESCALE, default 50000, is the number of clk cycles each digit is lit; legal range 2..2^20.
REQ-003 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port value, input, 4*NUM_DIGITS, holds the nibble per digit; digit k is value[4k+3:4k], and digit 0 is least significant.
REQ-006 Port load, input, 1, captures value into the display register when high on a clk edge.
REQ-007 Port hex_mode, input, 1: 1 shows nibbles A-F as glyphs, 0 shows nibbles above 9 as a dash.
REQ-008 Port blank, input, 1: 1 turns all segments and anodes off.
REQ-009 Port seg_n, output, 7, carries active-low segments {g,f,e,d,c,b,a}.
REQ-010 Port an_n, output, NUM_DIGITS, carries active-low one-hot digit enables.
REQ-011 Port frame_done, output, 1, is a one-cycle pulse at the end of each full scan.

Function
REQ-012 Prescaler: count runs 0..PRESCALE-1 and wraps; tick = (count == PRESCALE-1).
REQ-013 Digit index: advances by 1 on tick; wraps NUM_DIGITS-1 -> 0; holds otherwise.
REQ-014 frame_done: high for exactly the one cycle following a tick where index == NUM_DIGITS-1, i.e. registered together with the wrap.
REQ-015 Display register: load=1 -> disp <= value on the same edge; load=0 -> disp holds; load is accepted every cycle, with no busy state.
REQ-016 Outputs: seg_n and an_n are registered, with a 1-cycle latency from index/disp/hex_mode/blank to pins.
REQ-017 an_n: bit index = 0, all other bits = 1; when blank=1, all bits = 1.
REQ-018 seg_n glyphs (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-019 hex_mode=0: nibbles A-F -> seg_n = 3F (dash, g only); nibbles 0-9 are unchanged.
REQ-020 blank=1 -> seg_n = 7F; prescaler, index and frame_done keep running while blanked.
REQ-021 Simultaneous load and tick: the index advances and disp updates on the same edge; the next seg_n uses the new disp and new index.
REQ-022 Changing hex_mode or blank mid-frame: the change takes effect on the next edge, with no frame alignment.
REQ-023 NUM_DIGITS=1: index stays 0; frame_done pulses every PRESCALE cycles.

Reset
REQ-024 reset_n low, asynchronously: count=0, index=0, disp=0, seg_n=7F, an_n=all 1s, frame_done=0.
REQ-025 Reset asserted mid-frame or mid-load: all state is forced as in REQ-024 immediately, and a load on the release edge is ignored.
REQ-026 First edge after release: an_n = ~1 (digit 0 on), seg_n = 40, and the first tick occurs PRESCALE cycles after release.

Configuration
REQ-027 Macro SEG7_LEADING_ZERO_BLANK_EN, when defined, applies leading-zero blanking: a digit k>0 whose nibble is 0 and whose more-significant digits are all 0 shows seg_n = 7F, its anode stays enabled, and digit 0 is never blanked.
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN, when undefined, leaves every digit decoded per REQ-018/019 with no blanking logic present.

Verification
REQ-029 Bench parameters: NUM_DIGITS=4, PRESCALE=4 for all scenarios below.
REQ-030 Reset release, then value=16'h1234, load 1 cycle, hex_mode=1: the scan shows an_n E/D/B/7 with seg_n 19/30/24/79 (digit 0..3), 4 cycles each; frame_done pulses once every 16 cycles.
REQ-031 value=16'hABCF, hex_mode=0: seg_n = 3F on all digits; hex_mode=1: seg_n 0E/46/03/08 for digit 0..3.
REQ-032 Blank pulse: blank=1 for 6 cycles mid-digit gives seg_n=7F and an_n=F one cycle later; the scan phase and frame_done period are unchanged after release.
REQ-033 With the macro, value=16'h0050: digits 3 and 2 give seg_n=7F, digit 1 gives 12, digit 0 gives 40; without the macro, digits 3 and 2 give 40.
REQ-034 reset_n pulled low at index 2 with load=1 on the release edge: seg_n=7F and an_n=F while low; after release the display shows 0 on digit 0 and the loaded value is discarded.
